// File: rtl/vjtag_bus_ctrl.sv
// Virtual-JTAG to register-bus bridge.
// A 24-bit DR scan carries {address, data}; update-DR launches a single bus
// transaction that is tracked by a two-state FSM with an ack timeout.
// Read results are pipelined: they appear in the capture of the next READ scan.
module vjtag_bus_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tdi,
  output logic        tdo,
  input  logic [1:0]  ir_in,
  input  logic        virtual_state_cdr,
  input  logic        virtual_state_sdr,
  input  logic        virtual_state_udr,
  output logic        bus_req,
  output logic        bus_we,
  output logic [7:0]  bus_addr,
  output logic [15:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [15:0] bus_rdata
);

  localparam logic [1:0] IR_BYPASS = 2'b00;
  localparam logic [1:0] IR_WRITE  = 2'b01;
  localparam logic [1:0] IR_READ   = 2'b10;
  localparam logic [1:0] IR_STATUS = 2'b11;

  // Timer value at which a still-unacknowledged WAIT gives up; the abort edge
  // is the TIMEOUT-th edge spent in WAIT.
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t      state;
  logic [23:0] sr;
  logic        bypass_bit;
  logic [15:0] rdata_hold;
  logic [7:0]  timer;
  logic        timeout_err;
  logic        overflow_err;
  logic        last_we;

  logic        busy;
  logic        is_bus_op;
  logic        start;
  logic        overflow_hit;
  logic        status_clr;
  logic        timeout_hit;
  logic [7:0]  status;

  function automatic logic [7:0] pack_status(input logic b, input logic t,
                                             input logic o, input logic w);
    return {b, t, o, w, 4'b0000};
  endfunction

  assign busy         = (state == ST_WAIT);
  assign is_bus_op    = (ir_in == IR_WRITE) || (ir_in == IR_READ);
  assign start        = virtual_state_udr && is_bus_op && !busy;
  assign overflow_hit = virtual_state_udr && is_bus_op && busy;
  assign status_clr   = virtual_state_udr && (ir_in == IR_STATUS);
  // An ack in the final cycle wins, so the timeout only fires without ack.
  assign timeout_hit  = busy && !bus_ack && (timer == TIMER_LAST);
  assign status       = pack_status(busy, timeout_err, overflow_err, last_we);

  // tdo is held low during reset even before the first reset edge clears the registers.
  assign tdo = !reset && ((ir_in == IR_BYPASS) ? bypass_bit : sr[0]);

  // Scan chain: capture/shift of the bypass bit or the 24-bit data register (udr > cdr > sdr).
  always_ff @(posedge clk) begin
    if (reset) begin
      sr         <= '0;
      bypass_bit <= 1'b0;
    end else if (!virtual_state_udr) begin
      if (virtual_state_cdr) begin
        case (ir_in)
          IR_BYPASS: bypass_bit <= 1'b0;
          IR_WRITE:  sr <= '0;
          IR_READ:   sr <= {status, rdata_hold};
          IR_STATUS: sr <= {status, 16'h0000};
        endcase
      end else if (virtual_state_sdr) begin
        if (ir_in == IR_BYPASS) begin
          bypass_bit <= tdi;
        end else begin
          sr <= {tdi, sr[23:1]};
        end
      end
    end
  end

  // Bus FSM: launch on update-DR, complete on ack, abort on timeout; error flags are sticky.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= '0;
      bus_wdata    <= '0;
      timer        <= '0;
      rdata_hold   <= '0;
      timeout_err  <= 1'b0;
      overflow_err <= 1'b0;
      last_we      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            bus_req   <= 1'b1;
            bus_we    <= (ir_in == IR_WRITE);
            bus_addr  <= sr[23:16];
            bus_wdata <= sr[15:0];
            last_we   <= (ir_in == IR_WRITE);
            timer     <= '0;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (!bus_we) begin
              rdata_hold <= bus_rdata;
            end
            state <= ST_IDLE;
          end else if (timeout_hit) begin
            bus_req    <= 1'b0;
            rdata_hold <= 16'hDEAD;
            state      <= ST_IDLE;
          end else begin
            timer <= timer + 8'd1;
          end
        end
      endcase
      // Setting an error in the same cycle as a STATUS clear leaves it set.
      timeout_err  <= timeout_hit  | (timeout_err  & ~status_clr);
      overflow_err <= overflow_hit | (overflow_err & ~status_clr);
    end
  end

endmodule

// File: doc/vjtag_bus_ctrl.md
VJTAG_BUS_CTRL -- requirements
Module: vjtag_bus_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning clk cycles to wait for bus_ack before abort (legal range 1..255).
REQ-002 SHALL have ports:
- clk  in  1  JTAG TCK from the virtual JTAG hub; sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- tdi  in  1  scan data in.
- tdo  out  1  scan data out.
- ir_in  in  2  virtual instruction.
- virtual_state_cdr  in  1  capture-DR.
- virtual_state_sdr  in  1  shift-DR.
- virtual_state_udr  in  1  update-DR.
- bus_req  out  1  transaction request.
- bus_we  out  1  1 = write, 0 = read.
- bus_addr  out  8  register address.
- bus_wdata  out  16  write data.
- bus_ack  in  1  completion from the register bus.
- bus_rdata  in  16  read data, valid while bus_ack = 1.

Function
REQ-003 SHALL decode ir_in as: 00 BYPASS, 01 WRITE, 10 READ, 11 STATUS.
REQ-004 SHALL use a 1-bit bypass register in BYPASS:
- cdr loads 0.
- sdr loads tdi.
- tdo = bypass bit.
REQ-005 SHALL use a 24-bit shift register sr for all non-BYPASS instructions:
- sr[23:16] = address, sr[15:0] = data.
- sdr shifts right each cycle, tdi enters sr[23].
- tdo = sr[0], LSB first.
REQ-006 SHALL apply these capture-DR loads:
- WRITE: sr <= 0.
- READ: sr <= {status, rdata_hold}.
- STATUS: sr <= {status, 16'h0000}.
REQ-007 SHALL define status[7:0] = {busy, timeout_err, overflow_err, last_we, 4'b0000}.
REQ-008 SHALL, on udr with WRITE, issue a write with addr = sr[23:16] and wdata = sr[15:0].
REQ-009 SHALL, on udr with READ, issue a read with addr = sr[23:16]; the result is returned by the capture of the next READ scan (pipelined read).
REQ-010 SHALL, on udr with STATUS, clear timeout_err and overflow_err; no bus transaction is issued.
REQ-011 SHALL implement the bus FSM as follows:
- States: IDLE, WAIT.
- IDLE + start: on the next edge bus_req = 1, bus_we/bus_addr/bus_wdata latched, timer = 0, state -> WAIT.
- WAIT + bus_ack = 1: on the next edge bus_req = 0 and state -> IDLE; on a read, rdata_hold <= bus_rdata in the same edge.
- WAIT + no ack: timer increments each cycle; when timer reaches TIMEOUT with no ack, bus_req = 0, timeout_err = 1, rdata_hold <= 16'hDEAD, state -> IDLE.
REQ-012 SHALL hold bus_we, bus_addr and bus_wdata stable while bus_req = 1.
REQ-013 SHALL set busy = 1 exactly while state = WAIT.
REQ-014 SHALL drop a WRITE/READ udr that arrives while busy, set overflow_err = 1, and leave the in-flight transaction untouched.
REQ-015 SHALL ignore bus_ack while state = IDLE.
REQ-016 SHALL give ack priority over timeout when ack arrives in the timeout cycle: the transaction completes normally and no error is set.
REQ-017 SHALL, when udr STATUS and an error-setting event fall in the same cycle, leave the error set (set wins over clear).
REQ-018 SHALL set last_we to the bus_we value of the most recently started transaction.
REQ-019 SHALL treat cdr, sdr and udr as mutually exclusive; if more than one is asserted, priority is udr > cdr > sdr.
REQ-020 SHALL have a latency of 1 cycle from udr to bus_req, and 1 cycle from bus_ack to bus_req deassertion.

Reset
REQ-021 SHALL, while reset = 1, force:
- bus_req, bus_we, bus_addr, bus_wdata = 0.
- tdo = 0.
- sr, bypass = 0.
- rdata_hold = 0.
- errors = 0, last_we = 0, timer = 0.
- state = IDLE.
REQ-022 SHALL, when reset is asserted mid-transaction, abort the transaction with bus_req = 0 on the next edge and set no error flag.

Verification
REQ-023 Write: WRITE scan of addr 0x12 / data 0xBEEF, ack 3 cycles after req -> bus_req high 1 cycle after udr with we = 1, addr = 0x12, wdata = 0xBEEF, low 1 cycle after ack.
REQ-024 Read: READ scan addr 0x34, bus_rdata = 0x5A5A with ack, then a second READ scan -> shifted-out data[15:0] = 0x5A5A, status busy = 0, last_we = 0.
REQ-025 Timeout: READ with no ack, TIMEOUT = 15 -> bus_req low after 15 WAIT cycles, STATUS scan shows timeout_err = 1, next READ capture data = 0xDEAD.
REQ-026 Overflow / clear: second WRITE udr while busy -> in-flight addr unchanged, overflow_err = 1; a following STATUS udr -> both errors = 0.
REQ-027 Bypass / reset: BYPASS shift of 1,0,1 -> tdo delayed by one cycle; reset pulse during WAIT -> bus_req = 0 next edge, status = 0x00.
